// File: rtl/axi_helper.sv
// Shared AXI4-Lite helper types.
// resp_t   : the four AXI response codes.
// WxDATA_t : captured write-data beat (data + byte strobes).
// RxDATA_t : outgoing read beat (data + response).
package axi_helper;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_t;

    localparam int unsigned AXI_DATA_W = 32;
    localparam int unsigned AXI_STRB_W = AXI_DATA_W / 8;

    typedef struct packed {
        logic [AXI_DATA_W-1:0] data;
        logic [AXI_STRB_W-1:0] strb;
    } WxDATA_t;

    localparam int unsigned WxDATA_W = AXI_DATA_W + AXI_STRB_W;

    typedef struct packed {
        logic [AXI_DATA_W-1:0] data;
        resp_t                 resp;
    } RxDATA_t;

    localparam int unsigned RxDATA_W = AXI_DATA_W + 2;

endpackage

// File: rtl/lite_subordinate_if.sv
// AXI4-Lite bus bundle shared by the manager and the subordinate.
// master modport: drives AW/W/AR payload+valid and B/R ready.
// slave modport : drives AW/W/AR ready and B/R response+valid.
interface lite_subordinate_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) ();
    localparam int unsigned STRB_W = DATA_W / 8;

    logic [ADDR_W-1:0] awaddr;
    logic              awvalid;
    logic              awready;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;
    logic [ADDR_W-1:0] araddr;
    logic              arvalid;
    logic              arready;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

endinterface

// File: rtl/strb_ram.sv
// DEPTH x DATA_W RAM, one byte-strobed synchronous write port and one
// synchronous read port. No reset. A read and a write to the same word on
// the same edge return the old contents.
// Ports: clk; we/waddr/wstrb/wdata write port; re/raddr/rdata read port.
module strb_ram #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 1024,
    localparam int         STRB_W = DATA_W / 8,
    localparam int         IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [STRB_W-1:0] wstrb,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [IDX_W-1:0]  raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Non-blocking read and write in one process give read-before-write.
    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem[raddr];
        end
        if (we) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (wstrb[b]) begin
                    mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/lite_subordinate.sv
// AXI4-Lite subordinate backed by a byte-strobed RAM of DEPTH words.
// In-range accesses return OKAY, accesses at or above DEPTH*STRB_W bytes
// return SLVERR (writes dropped, reads return zero).
// Ports: clk, rst_n (async active-low), bus (slave modport of the AXI bundle).
module lite_subordinate
    import axi_helper::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = AXI_DATA_W,
    parameter int unsigned DEPTH  = 1024
) (
    input logic               clk,
    input logic               rst_n,
    lite_subordinate_if.slave bus
);

    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned IDX_W  = $clog2(DEPTH);
    localparam int unsigned LSB    = $clog2(STRB_W);
    localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(DEPTH * STRB_W);

    typedef enum logic [1:0] {WIdle, WCollect, WCommit, WResp} w_state_e;
    typedef enum logic {RIdle, RValid} r_state_e;

    w_state_e w_state_q, w_state_d;
    r_state_e r_state_q, r_state_d;

    // Holds the readies low until the first edge after reset release.
    logic rst_done_q;

    logic             aw_full_q, aw_full_d;
    logic             w_full_q, w_full_d;
    logic [IDX_W-1:0] aw_idx_q;
    logic             aw_err_q;
    WxDATA_t          w_q;
    logic             b_err_q;
    logic             r_err_q;

    logic awready, wready, arready, bvalid, rvalid;
    logic aw_hs, w_hs, ar_hs, ar_in_range, commit;

    logic              ram_we, ram_re;
    logic [IDX_W-1:0]  ar_idx;
    logic [DATA_W-1:0] ram_rdata;
    RxDATA_t           r_out;

    // Readies and valids come only from registered state.
    assign bvalid  = (w_state_q == WResp);
    assign rvalid  = (r_state_q == RValid);
    assign awready = rst_done_q && !aw_full_q && !bvalid;
    assign wready  = rst_done_q && !w_full_q && !bvalid;
    assign arready = rst_done_q && !rvalid;

    assign aw_hs  = bus.awvalid && awready;
    assign w_hs   = bus.wvalid && wready;
    assign ar_hs  = bus.arvalid && arready;
    assign commit = (w_state_q == WCommit);

    assign ar_in_range = (bus.araddr < ADDR_LIMIT);
    assign ar_idx      = bus.araddr[LSB +: IDX_W];
    assign ram_re      = ar_hs && ar_in_range;
    assign ram_we      = commit && !aw_err_q;

    always_comb begin
        w_state_d = w_state_q;
        aw_full_d = aw_full_q;
        w_full_d  = w_full_q;
        unique case (w_state_q)
            WIdle, WCollect: begin
                if (aw_hs) aw_full_d = 1'b1;
                if (w_hs)  w_full_d  = 1'b1;
                if (aw_full_d && w_full_d) begin
                    w_state_d = WCommit;
                end else if (aw_full_d || w_full_d) begin
                    w_state_d = WCollect;
                end else begin
                    w_state_d = WIdle;
                end
            end
            WCommit: begin
                aw_full_d = 1'b0;
                w_full_d  = 1'b0;
                w_state_d = WResp;
            end
            WResp: begin
                if (bus.bready) w_state_d = WIdle;
            end
        endcase
    end

    always_comb begin
        r_state_d = r_state_q;
        unique case (r_state_q)
            RIdle:  if (ar_hs) r_state_d = RValid;
            RValid: if (bus.rready) r_state_d = RIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_state_q  <= WIdle;
            r_state_q  <= RIdle;
            rst_done_q <= 1'b0;
            aw_full_q  <= 1'b0;
            w_full_q   <= 1'b0;
            aw_idx_q   <= '0;
            aw_err_q   <= 1'b0;
            w_q        <= '0;
            b_err_q    <= 1'b0;
            r_err_q    <= 1'b0;
        end else begin
            w_state_q  <= w_state_d;
            r_state_q  <= r_state_d;
            rst_done_q <= 1'b1;
            aw_full_q  <= aw_full_d;
            w_full_q   <= w_full_d;
            if (aw_hs) begin
                aw_idx_q <= bus.awaddr[LSB +: IDX_W];
                aw_err_q <= !(bus.awaddr < ADDR_LIMIT);
            end
            if (w_hs) begin
                w_q.data <= bus.wdata;
                w_q.strb <= bus.wstrb;
            end
            if (commit) b_err_q <= aw_err_q;
            if (ar_hs)  r_err_q <= !ar_in_range;
        end
    end

    strb_ram #(
        .DATA_W(DATA_W),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk  (clk),
        .we   (ram_we),
        .waddr(aw_idx_q),
        .wstrb(w_q.strb),
        .wdata(w_q.data),
        .re   (ram_re),
        .raddr(ar_idx),
        .rdata(ram_rdata)
    );

    // RAM output is undefined after reset and stale after an error read,
    // so it only reaches the bus for a valid in-range beat.
    always_comb begin
        r_out.data = (rvalid && !r_err_q) ? ram_rdata : '0;
        r_out.resp = r_err_q ? SLVERR : OKAY;
    end

    assign bus.awready = awready;
    assign bus.wready  = wready;
    assign bus.arready = arready;
    assign bus.bvalid  = bvalid;
    assign bus.bresp   = b_err_q ? SLVERR : OKAY;
    assign bus.rvalid  = rvalid;
    assign bus.rdata   = r_out.data;
    assign bus.rresp   = r_out.resp;

endmodule

// File: tb/tb_lite_subordinate.sv
module tb_lite_subordinate;
    import axi_helper::*;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned DEPTH  = 1024;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    lite_subordinate_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    lite_subordinate #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .DEPTH (DEPTH)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] rdy3();
        return 64'({bus.awready, bus.wready, bus.arready});
    endfunction

    // AW and W in the same cycle; BVALID expected two cycles after handshake.
    task automatic write_check(input string tag, input logic [31:0] addr,
                               input logic [31:0] data, input logic [3:0] strb,
                               input logic [1:0] exp_resp);
        bus.awaddr = addr; bus.awvalid = 1'b1;
        bus.wdata = data; bus.wstrb = strb; bus.wvalid = 1'b1;
        tick();
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        check({tag, " bvalid N+1"}, 64'(bus.bvalid), 64'(0));
        tick();
        check({tag, " bvalid N+2"}, 64'(bus.bvalid), 64'(1));
        check({tag, " bresp"}, 64'(bus.bresp), 64'(exp_resp));
        tick();
        check({tag, " bvalid drop"}, 64'(bus.bvalid), 64'(0));
    endtask

    task automatic read_check(input string tag, input logic [31:0] addr,
                              input logic [31:0] exp_data, input logic [1:0] exp_resp);
        bus.araddr = addr; bus.arvalid = 1'b1;
        tick();
        bus.arvalid = 1'b0;
        check({tag, " rvalid"}, 64'(bus.rvalid), 64'(1));
        check({tag, " rdata"}, 64'(bus.rdata), 64'(exp_data));
        check({tag, " rresp"}, 64'(bus.rresp), 64'(exp_resp));
        tick();
        check({tag, " rvalid drop"}, 64'(bus.rvalid), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.awaddr = '0; bus.awvalid = 1'b0;
        bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0;
        bus.araddr = '0; bus.arvalid = 1'b0;
        bus.bready = 1'b1; bus.rready = 1'b1;

        // Reset state
        #2;
        check("rst readies", rdy3(), 64'(3'b000));
        check("rst valids", 64'({bus.bvalid, bus.rvalid}), 64'(2'b00));
        check("rst rdata", 64'(bus.rdata), 64'(0));
        check("rst resps", 64'({bus.bresp, bus.rresp}), 64'(4'b0000));
        tick(); tick();
        rst_n = 1'b1;
        tick();
        check("idle readies", rdy3(), 64'(3'b111));
        check("idle valids", 64'({bus.bvalid, bus.rvalid}), 64'(2'b00));

        // Basic write and readback
        write_check("wr10", 32'h10, 32'hDEADBEEF, 4'hF, OKAY);
        check("wr10 readies back", rdy3(), 64'(3'b111));
        read_check("rd10", 32'h10, 32'hDEADBEEF, OKAY);

        // W one cycle ahead of AW, single byte lane
        bus.wdata = 32'h000000AA; bus.wstrb = 4'h1; bus.wvalid = 1'b1;
        tick();
        bus.wvalid = 1'b0;
        check("wfirst wready held", 64'(bus.wready), 64'(0));
        check("wfirst awready", 64'(bus.awready), 64'(1));
        tick();
        check("wfirst wready still", 64'(bus.wready), 64'(0));
        bus.awaddr = 32'h10; bus.awvalid = 1'b1;
        tick();
        bus.awvalid = 1'b0;
        check("wfirst commit cycle", 64'({bus.awready, bus.wready, bus.bvalid}), 64'(3'b000));
        tick();
        check("wfirst bvalid", 64'(bus.bvalid), 64'(1));
        check("wfirst bresp", 64'(bus.bresp), 64'(OKAY));
        tick();
        check("wfirst readies back", 64'({bus.awready, bus.wready, bus.bvalid}), 64'(3'b110));
        read_check("rd10 merged", 32'h10, 32'hDEADBEAA, OKAY);

        // Out of range (0x1000 aliases word 0 in the index bits)
        write_check("wr0", 32'h0, 32'hCAFEF00D, 4'hF, OKAY);
        write_check("wr oob", 32'h1000, 32'h12345678, 4'hF, SLVERR);
        read_check("rd oob", 32'h1000, 32'h0, SLVERR);
        read_check("rd0 intact", 32'h0, 32'hCAFEF00D, OKAY);

        // Zero strobe writes nothing but answers OKAY
        write_check("wr strb0", 32'h0, 32'hFFFFFFFF, 4'h0, OKAY);
        read_check("rd0 strb0", 32'h0, 32'hCAFEF00D, OKAY);

        // Last in-range word; low address bits ignored
        write_check("wr last", 32'hFFC, 32'h0BADCAFE, 4'hF, OKAY);
        read_check("rd last unaligned", 32'hFFE, 32'h0BADCAFE, OKAY);

        // Read on the commit edge of a write to the same word sees old data
        write_check("wr18", 32'h18, 32'h55555555, 4'hF, OKAY);
        bus.awaddr = 32'h18; bus.awvalid = 1'b1;
        bus.wdata = 32'h66666666; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
        tick();
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        bus.araddr = 32'h18; bus.arvalid = 1'b1;
        tick();
        bus.arvalid = 1'b0;
        check("collide bvalid", 64'(bus.bvalid), 64'(1));
        check("collide rvalid", 64'(bus.rvalid), 64'(1));
        check("collide rdata old", 64'(bus.rdata), 64'(32'h55555555));
        tick();
        read_check("rd18 new", 32'h18, 32'h66666666, OKAY);

        // Backpressure on both response channels
        bus.bready = 1'b0; bus.rready = 1'b0;
        bus.awaddr = 32'h14; bus.awvalid = 1'b1;
        bus.wdata = 32'h11223344; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
        bus.araddr = 32'h10; bus.arvalid = 1'b1;
        tick();
        bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
        check("bp rvalid first", 64'({bus.bvalid, bus.rvalid}), 64'(2'b01));
        tick();
        for (int i = 0; i < 5; i++) begin
            check("bp valids", 64'({bus.bvalid, bus.rvalid}), 64'(2'b11));
            check("bp rdata", 64'(bus.rdata), 64'(32'hDEADBEAA));
            check("bp resps", 64'({bus.bresp, bus.rresp}), 64'(4'b0000));
            check("bp readies", rdy3(), 64'(3'b000));
            tick();
        end
        bus.bready = 1'b1; bus.rready = 1'b1;
        tick();
        check("bp release valids", 64'({bus.bvalid, bus.rvalid}), 64'(2'b00));
        check("bp release readies", rdy3(), 64'(3'b111));
        read_check("rd14", 32'h14, 32'h11223344, OKAY);

        // Reset with AW captured and W outstanding
        bus.awaddr = 32'h20; bus.awvalid = 1'b1;
        tick();
        bus.awvalid = 1'b0;
        check("midrst aw held", 64'({bus.awready, bus.wready}), 64'(2'b01));
        rst_n = 1'b0;
        #1;
        check("midrst readies low", rdy3(), 64'(3'b000));
        tick();
        rst_n = 1'b1;
        tick();
        check("midrst readies back", rdy3(), 64'(3'b111));
        bus.wdata = 32'h00000077; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
        tick();
        bus.wvalid = 1'b0;
        tick(); tick();
        check("midrst no stale commit", 64'({bus.bvalid, bus.awready}), 64'(2'b01));
        bus.awaddr = 32'h20; bus.awvalid = 1'b1;
        tick();
        bus.awvalid = 1'b0;
        tick();
        check("midrst bvalid", 64'(bus.bvalid), 64'(1));
        check("midrst bresp", 64'(bus.bresp), 64'(OKAY));
        tick();
        read_check("rd20", 32'h20, 32'h00000077, OKAY);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
